mac_stream_sequencer: RTL
=========================

# mac_stream_sequencer

Controller and datapath wrapper that sequences a signed multiply-accumulate over a configured number of operand pairs. A job is accepted on a config handshake; the block then pulls exactly `cfg_len` operand pairs from a valid/ready stream, accumulates their products, and presents the dot-product result on a valid/ready output. It sits between the operand streamers and the result collector in the compute path. It replaces free-running accumulation with explicit start, clear and done semantics.

## Interface
- `DATA_W`, 8: operand width, signed two's complement.
- `ACC_W`, 24: accumulator and result width, signed; must satisfy ACC_W ≥ 2·DATA_W.
- `LEN_W`, 10: width of the pair count; maximum job length is 2^LEN_W − 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  job request.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_len`  in  LEN_W  number of operand pairs in the job; sampled on the cfg handshake.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in RUN.
- `in_a`, `in_b`  in  DATA_W each  signed operands.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  result consumer ready.
- `out_result`  out  ACC_W  signed accumulated sum.
- `out_overflow`  out  1  sticky signed-overflow flag for the current job.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE → RUN:** on `cfg_valid && cfg_ready` with `cfg_len` ≠ 0.
  - Latch `cfg_len`.
  - Zero the element counter, the accumulator and `out_overflow`.
- **IDLE → DONE:** on a cfg handshake with `cfg_len` = 0. The accumulator and overflow are still cleared, so the result is 0.
- **RUN:** each `in_valid && in_ready` edge captures `in_a`/`in_b` into the operand registers, sets stage-1 valid and increments the counter.
  - The handshake on which the counter equals `len−1` is the last one; it moves the block to DRAIN.
  - `in_valid` gaps are allowed; the counter and state hold during gaps.
- **DRAIN:** one cycle. The final product is accumulated on the DRAIN edge, then the block moves to DONE.
- **DONE:** `out_valid` is held high and `out_result` is held stable until `out_ready`. On the `out_valid && out_ready` edge the block moves to IDLE.
- A cfg request cannot be accepted in the same cycle as the output handshake, because `cfg_ready` is 0 in DONE.
- `out_result` keeps its last value in IDLE until the next cfg handshake clears it.
- **Arithmetic:**
  - product = in_a × in_b, full 2·DATA_W-bit signed, sign-extended to ACC_W.
  - The accumulator wraps in two's complement.
  - `out_overflow` is set on any add where both operands have the same sign and the sum's sign differs. It stays set until the next job starts.
- **Reset, including mid-job:** state IDLE, counter 0, accumulator 0, stage-1 valid 0. Any in-flight job is discarded with no output.
- **Output values during and right after reset:** `cfg_ready` = 1, `in_ready` = 0, `out_valid` = 0, `out_result` = 0, `out_overflow` = 0.

## Timing
- **Operand pipeline:** two stages. The operand register is captured on the accept edge; the product is added to the accumulator on the following edge.
- **Result latency:** the last input handshake at edge k gives DRAIN after k, accumulation at edge k+1, and `out_valid` = 1 in the cycle after k+1.
- **len = 0:** a cfg handshake at edge e gives `out_valid` = 1 in the cycle after e.
- **Throughput:** one pair per cycle while in RUN. Back-to-back jobs cost 3 cycles of overhead (DRAIN, DONE, IDLE) when `out_ready` is held high.
- `cfg_ready`, `in_ready` and `out_valid` are decoded from registered state only. They never depend combinationally on the opposite handshake input.

## Structure
- **Package `mac_seq_pkg`:**
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default widths `DATA_W`/`ACC_W`/`LEN_W` as localparams;
  - an overflow-detect function.
- **Sub-module `mac_unit`:**
  - operand registers and the stage-1 valid flag;
  - signed multiplier and accumulator;
  - inputs `load`, `clear`; outputs `acc`, `ovf`.
- **Top level:** holds the FSM, the counter and the handshake decode.

## Test plan
- cfg_len = 4, with a = {1, 2, 3, 4} and b = {5, 6, 7, 8} sent back-to-back → `out_result` = 70, `out_overflow` = 0, `out_valid` 2 cycles after the last accept.
- cfg_len = 1, with a = −128 and b = −128 → 16384. Then cfg_len = 2 with {−128, 127} × {127, 127} → −128·127 + 127·127 = −127.
- cfg_len = 512, with every pair = (−128, −128) → `out_result` = −8388608 (wrapped), `out_overflow` = 1. A following job with len = 1 and (1, 1) → 1, `out_overflow` = 0.
- cfg_len = 3 with random `in_valid` gaps, and `out_ready` held low for 5 cycles in DONE → `in_ready` is 0 after the 3rd accept; the result stays stable and `out_valid` stays 1 until `out_ready`; then `cfg_ready` = 1 in the next cycle.
- cfg_len = 0 → `in_ready` never asserts, `out_result` = 0, `out_valid` = 1 in the cycle after the cfg handshake.
- Assert `reset_n` low after 2 of 4 accepts → all outputs return to their reset values immediately. A new job with len = 2, (3, 3) and (2, −5), gives −1 with no residue from the aborted job.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types, default widths and arithmetic helpers for the MAC stream sequencer.
package mac_seq_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 24;
  localparam int MAC_LEN_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Signed add overflows when both addends share a sign that the sum does not.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Two-stage signed multiply-accumulate: operand capture, then product accumulation.
module mac_unit
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W  = MAC_ACC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf
);

  logic signed [DATA_W-1:0]   r_a_p0;
  logic signed [DATA_W-1:0]   r_b_p0;
  logic                       r_vld_p0;
  logic signed [ACC_W-1:0]    r_acc_p1;
  logic                       r_ovf_p1;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_sum;

  assign w_prod     = r_a_p0 * r_b_p0;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = r_acc_p1 + w_prod_ext;

  // Stage 0: operand capture
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_a_p0 <= $signed(i_a);
      r_b_p0 <= $signed(i_b);
    end
  end

  // Stage 1: accumulate the captured product; clear starts a fresh job
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p0 <= 1'b0;
      r_acc_p1 <= '0;
      r_ovf_p1 <= 1'b0;
    end else if (i_clear) begin
      r_vld_p0 <= 1'b0;
      r_acc_p1 <= '0;
      r_ovf_p1 <= 1'b0;
    end else begin
      r_vld_p0 <= i_load;
      if (r_vld_p0) begin
        r_acc_p1 <= w_sum;
        r_ovf_p1 <= r_ovf_p1 |
                    add_ovf(r_acc_p1[ACC_W-1], w_prod_ext[ACC_W-1], w_sum[ACC_W-1]);
      end
    end
  end

  assign o_acc = r_acc_p1;
  assign o_ovf = r_ovf_p1;

endmodule

// File: rtl/mac_stream_sequencer.sv
// Job sequencer: accepts a length, pulls that many operand pairs, presents the dot product.
module mac_stream_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int LEN_W  = MAC_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [LEN_W-1:0]  i_cfg_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_a,
  input  logic [DATA_W-1:0] i_in_b,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_result,
  output logic              o_out_overflow
);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             w_cfg_hs;
  logic             w_in_hs;

  assign w_cfg_hs = i_cfg_valid && (r_state == ST_IDLE);
  assign w_in_hs  = i_in_valid && (r_state == ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_valid) begin
            r_len   <= i_cfg_len;
            r_cnt   <= '0;
            r_state <= (i_cfg_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_in_valid) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (r_cnt == r_len - LEN_W'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE:  if (i_out_ready) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags come from registered state only, never from the peer's input.
  assign o_cfg_ready = (r_state == ST_IDLE);
  assign o_in_ready  = (r_state == ST_RUN);
  assign o_out_valid = (r_state == ST_DONE);

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset_n(reset_n),
    .i_load (w_in_hs),
    .i_clear(w_cfg_hs),
    .i_a    (i_in_a),
    .i_b    (i_in_b),
    .o_acc  (o_out_result),
    .o_ovf  (o_out_overflow)
  );

endmodule
